// File: rtl/shift_pkg.sv
// Shared op encodings, FSM states and count-width helper for the sequential shifter.
package shift_pkg;

  localparam logic [2:0] OP_SHR  = 3'b000;
  localparam logic [2:0] OP_SHRA = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_ROR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Count must hold the value WIDTH itself (full shift-out), hence the extra bit.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

  localparam int DEF_WIDTH = 32;
  localparam int CNT_W     = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/shift_step.sv
// One combinational shift/rotate step of 0..STEP bit positions; no state.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int KW    = $clog2(STEP) + 1
) (
  input  logic [WIDTH-1:0] value,
  input  logic [2:0]       op,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] shifted
);

  always_comb begin
    shifted = value;
    case (op)
      OP_SHR:  shifted = value >> k;
      OP_SHRA: shifted = $signed(value) >>> k;
      OP_SHL:  shifted = value << k;
      // k is always below WIDTH for rotates, so the wrap term is well-defined.
      OP_ROR:  shifted = (value >> k) | (value << (WIDTH - int'(k)));
      OP_ROL:  shifted = (value << k) | (value >> (WIDTH - int'(k)));
      default: shifted = value;
    endcase
  end

endmodule

// File: rtl/shift_rotate_seq.sv
// Multi-cycle shifter/rotator moving up to STEP bits per cycle.
// done arrives ceil(count/STEP)+1 cycles after start; start is ignored while busy.
module shift_rotate_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] amt,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CW = cnt_width(WIDTH);
  localparam int LW = $clog2(WIDTH);
  localparam int KW = $clog2(STEP) + 1;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_val;
  logic [WIDTH-1:0] r_result;
  logic [2:0]       r_op;
  logic [CW-1:0]    r_rem;
  logic             r_err;

  logic             w_legal;
  logic             w_accept;
  logic [CW-1:0]    w_count;
  logic [KW-1:0]    w_k;
  logic [CW-1:0]    w_rem_next;
  logic [WIDTH-1:0] w_step_val;

  assign w_legal  = (op <= OP_ROL);
  assign w_accept = start && (r_state != SHIFT);

  always_comb begin
    w_count = '0;
    if (!w_legal) begin
      w_count = '0;
    end else if (op == OP_ROR || op == OP_ROL) begin
      w_count = CW'(amt[LW-1:0]);
    end else if (amt >= WIDTH'(WIDTH)) begin
      w_count = CW'(WIDTH);
    end else begin
      w_count = amt[CW-1:0];
    end
  end

  assign w_k        = (r_rem >= CW'(STEP)) ? KW'(STEP) : KW'(r_rem);
  assign w_rem_next = r_rem - CW'(w_k);

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .KW    (KW)
  ) u_step (
    .value   (r_val),
    .op      (r_op),
    .k       (w_k),
    .shifted (w_step_val)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (start) w_next = (w_count != '0) ? SHIFT : DONE;
        else       w_next = IDLE;
      end
      SHIFT:   if (w_rem_next == '0) w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state  <= IDLE;
      r_val    <= '0;
      r_result <= '0;
      r_op     <= '0;
      r_rem    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_val <= a;
        r_op  <= op;
        r_rem <= w_count;
        r_err <= !w_legal;
        if (w_count == '0) r_result <= a;
      end else if (r_state == SHIFT) begin
        r_val <= w_step_val;
        r_rem <= w_rem_next;
        if (w_rem_next == '0) r_result <= w_step_val;
      end
    end
  end

  assign result = r_result;
  assign busy   = (r_state == SHIFT);
  assign done   = (r_state == DONE);
  assign err    = (r_state == DONE) && r_err;

endmodule

// File: tb/tb_shift_rotate_seq.sv
// Directed bench for shift_rotate_seq: one STEP=1 and one STEP=4 instance.
module tb_shift_rotate_seq;

  logic        clock = 1'b0;
  logic        clear;
  logic        start1, start4;
  logic [2:0]  op;
  logic [31:0] a, amt;
  logic [31:0] res1, res4;
  logic        busy1, done1, err1, busy4, done4, err4;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  shift_rotate_seq #(.WIDTH(32), .STEP(1)) dut1 (
    .clock(clock), .clear(clear), .start(start1), .op(op), .a(a), .amt(amt),
    .result(res1), .busy(busy1), .done(done1), .err(err1)
  );

  shift_rotate_seq #(.WIDTH(32), .STEP(4)) dut4 (
    .clock(clock), .clear(clear), .start(start4), .op(op), .a(a), .amt(amt),
    .result(res4), .busy(busy4), .done(done4), .err(err4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Called at a falling edge; returns 1ns after the rising edge that samples start.
  task automatic issue(input int sel, input logic [2:0] o, input logic [31:0] va,
                       input logic [31:0] vamt);
    op  = o;
    a   = va;
    amt = vamt;
    if (sel == 1) start4 = 1'b1;
    else          start1 = 1'b1;
    @(posedge clock);
    #1;
    start1 = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int sel, input int cyc0, input int exp_lat,
                           input logic [31:0] exp_res, input logic exp_err);
    int cycles;
    bit seen;
    cycles = cyc0;
    seen   = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clock);
      if ((sel == 1) ? done4 : done1) seen = 1'b1;
      else begin
        @(posedge clock);
        cycles++;
      end
    end
    if (!seen) cycles = -1;
    check({tag, "_lat"}, 32'(cycles), 32'(exp_lat));
    check({tag, "_res"}, (sel == 1) ? res4 : res1, exp_res);
    check({tag, "_err"}, 32'((sel == 1) ? err4 : err1), 32'(exp_err));
  endtask

  initial begin
    int pulses;
    clear  = 1'b1;
    start1 = 1'b0;
    start4 = 1'b0;
    op     = 3'b000;
    a      = 32'h0;
    amt    = 32'h0;
    repeat (2) @(negedge clock);
    check("rst_res",  res1, 32'h0);
    check("rst_busy", 32'(busy1), 32'h0);
    check("rst_done", 32'(done1), 32'h0);
    check("rst_err",  32'(err1), 32'h0);
    check("rst_res4", res4, 32'h0);

    // First start right at the first edge after clear drops.
    clear = 1'b0;
    issue(0, 3'b100, 32'hABCD1234, 32'd8);
    wait_done("rol8", 0, 1, 9, 32'hCD1234AB, 1'b0);

    @(negedge clock); issue(1, 3'b011, 32'hABCD1234, 32'd36);
    wait_done("ror36_s4", 1, 1, 2, 32'h4ABCD123, 1'b0);
    @(negedge clock); issue(1, 3'b010, 32'h00000001, 32'd6);
    wait_done("shl6_s4", 1, 1, 3, 32'h00000040, 1'b0);
    @(negedge clock); issue(1, 3'b001, 32'h80000000, 32'd32);
    wait_done("shra32_s4", 1, 1, 9, 32'hFFFFFFFF, 1'b0);

    @(negedge clock); issue(0, 3'b001, 32'h80000000, 32'd40);
    wait_done("shra40", 0, 1, 33, 32'hFFFFFFFF, 1'b0);
    @(negedge clock); issue(0, 3'b000, 32'h80000000, 32'd40);
    wait_done("shr40", 0, 1, 33, 32'h00000000, 1'b0);
    @(negedge clock); issue(0, 3'b010, 32'h00000001, 32'd0);
    wait_done("shl0", 0, 1, 1, 32'h00000001, 1'b0);
    @(negedge clock); issue(0, 3'b111, 32'h12345678, 32'd5);
    wait_done("illegal", 0, 1, 1, 32'h12345678, 1'b1);

    // Start pulsed mid-SHIFT with different operands must be ignored.
    @(negedge clock); issue(0, 3'b010, 32'h0000000F, 32'd4);
    @(negedge clock);
    check("busy_mid", 32'(busy1), 32'h1);
    issue(0, 3'b100, 32'hFFFF0000, 32'd3);
    wait_done("shl4_ign", 0, 2, 5, 32'h000000F0, 1'b0);

    // Back-to-back: start presented during the DONE cycle.
    issue(0, 3'b000, 32'h00000100, 32'd4);
    check("b2b_busy", 32'(busy1), 32'h1);
    check("b2b_hold", res1, 32'h000000F0);
    wait_done("b2b_shr", 0, 1, 5, 32'h00000010, 1'b0);

    // Clear in the middle of a long rotate.
    @(negedge clock); issue(0, 3'b100, 32'hABCD1234, 32'd20);
    repeat (5) @(negedge clock);
    check("pre_clr_busy", 32'(busy1), 32'h1);
    clear = 1'b1;
    #1;
    check("clr_res",  res1, 32'h0);
    check("clr_busy", 32'(busy1), 32'h0);
    check("clr_done", 32'(done1), 32'h0);
    @(negedge clock);
    clear  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      if (done1) pulses++;
    end
    check("clr_no_done", 32'(pulses), 32'h0);
    issue(0, 3'b100, 32'h12345678, 32'd4);
    wait_done("rol_after_clr", 0, 1, 5, 32'h23456781, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/shift_rotate_seq.md
SHIFT_ROTATE_SEQ -- requirements
Module: shift_rotate_seq

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width, power of 2, minimum 8.
REQ-002 Parameter STEP, default 1: maximum bit positions moved per shift cycle, power of 2, 1..WIDTH.
REQ-003 Port clock  input  1  sole clock, rising-edge.
REQ-004 Port clear  input  1  reset, asynchronous, active-high.
REQ-005 Port start  input  1  request; sampled on rising edge when not busy.
REQ-006 Port op  input  3  000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL, 101-111 illegal.
REQ-007 Port a  input  WIDTH  operand to shift/rotate.
REQ-008 Port amt  input  WIDTH  shift/rotate amount, unsigned.
REQ-009 Port result  output  WIDTH  final value, valid from done until next accepted start.
REQ-010 Port busy  output  1  high while operation in progress (SHIFT state).
REQ-011 Port done  output  1  single-cycle completion pulse.
REQ-012 Port err  output  1  high with done when op was illegal; low otherwise.

Function
REQ-013 FSM states IDLE, SHIFT, DONE; busy = (state == SHIFT); done = (state == DONE).
REQ-014 IDLE or DONE with start=1: latch a, op, effective count into internal registers; go to SHIFT if count>0, else DONE.
REQ-015 Rotates (ROR/ROL): count = amt mod WIDTH.
REQ-016 Shifts (SHR/SHRA/SHL): count = min(amt, WIDTH); count WIDTH yields all zeros (SHR/SHL) or full sign fill (SHRA).
REQ-017 Illegal op: count forced 0, result = a, err=1 during DONE.
REQ-018 Each SHIFT cycle: move working value by k = min(STEP, remaining); remaining -= k; SHR zero-fills MSBs, SHRA replicates bit WIDTH-1, SHL zero-fills LSBs, rotates wrap bits exactly.
REQ-019 SHIFT -> DONE on the edge where remaining becomes 0.
REQ-020 Latency: done high exactly ceil(count/STEP)+1 cycles after the edge sampling start (count 0: 1 cycle).
REQ-021 DONE -> IDLE next edge unless start=1 (then back-to-back accept per REQ-014).
REQ-022 start during SHIFT ignored; latched operands unchanged; no error raised.
REQ-023 result holds final value through IDLE; updates only on completion of next operation.
REQ-024 Input a/op/amt changes after acceptance have no effect on the running operation.

Reset
REQ-025 clear=1 at any time, including mid-SHIFT: state IDLE, result 0, busy 0, done 0, err 0, internal counters 0; in-flight operation discarded, no done pulse.
REQ-026 First start accepted on first rising edge after clear deasserts.

Structure
REQ-027 Package shift_pkg holds op encodings, FSM state enum, and the CLOG2-based count-width constant (clog2(WIDTH)+1 bits).
REQ-028 One sub-module shift_step: combinational single step, inputs value, op, k (0..STEP) -> shifted value; instantiated once.
REQ-029 All state in shift_rotate_seq; no latches; shift_step contains no registers.

Verification
REQ-030 WIDTH=32, STEP=1: ROL a=0xABCD1234 amt=8 -> result 0xCD1234AB, done 9 cycles after start, err 0.
REQ-031 STEP=4: ROR a=0xABCD1234 amt=36 (mod 32 = 4) -> result 0x4ABCD123, done 2 cycles after start.
REQ-032 STEP=1: SHRA a=0x80000000 amt=40 -> result 0xFFFFFFFF, done 33 cycles after start; SHR same inputs -> 0x00000000.
REQ-033 SHL a=0x00000001 amt=0 -> result 0x00000001 after 1 cycle; op=111 -> result=a, err=1 with done.
REQ-034 SHL a=0x0000000F amt=4 started; start with different operands pulsed mid-SHIFT -> ignored, result 0x000000F0; then start issued in DONE cycle -> accepted back-to-back.
REQ-035 clear asserted mid-SHIFT of ROL amt=20 -> immediately result 0, busy 0, no done pulse; new op after release completes correctly.
